// File: rtl/fp_add_arbiter.sv
// Two-requester arbiter in front of a shared 13-bit {sign, exp[3:0], frac[7:0]} adder.
// Winner's operands are captured, summed in one cycle and returned through valid/ready.
module fp_add_arbiter #(
  parameter bit RR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [12:0] a0,
  input  logic [12:0] b0,
  input  logic [12:0] a1,
  input  logic [12:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_id,
  output logic [12:0] out_result,
  output logic        out_ovf
);

  localparam int unsigned EW = 4;
  localparam int unsigned FW = 8;
  localparam int unsigned W  = 1 + EW + FW;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t         state;
  logic           ptr;
  logic           id;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           win;

  logic           a_big;
  logic           sign_big;
  logic           sign_sml;
  logic [EW-1:0]  exp_big;
  logic [EW-1:0]  exp_sml;
  logic [EW-1:0]  shamt;
  logic [FW-1:0]  frac_big;
  logic [FW-1:0]  frac_sml;
  logic [FW-1:0]  frac_aln;
  logic [FW:0]    sum;
  logic [2:0]     lz;
  logic           carry;
  logic [EW-1:0]  res_exp;
  logic [FW-1:0]  res_frac;
  logic           res_ovf;

  // Tie-break: pointer in round-robin mode, requester 0 otherwise
  always_comb begin
    win = 1'b0;
    if (req0 && req1) win = RR ? ptr : 1'b0;
    else              win = req1;
  end

  // Sort / align / add-sub / normalize on the captured operands
  always_comb begin
    a_big    = op_a[W-2:0] > op_b[W-2:0];
    sign_big = a_big ? op_a[W-1] : op_b[W-1];
    sign_sml = a_big ? op_b[W-1] : op_a[W-1];
    exp_big  = a_big ? op_a[W-2:FW] : op_b[W-2:FW];
    exp_sml  = a_big ? op_b[W-2:FW] : op_a[W-2:FW];
    frac_big = a_big ? op_a[FW-1:0] : op_b[FW-1:0];
    frac_sml = a_big ? op_b[FW-1:0] : op_a[FW-1:0];
    shamt    = exp_big - exp_sml;
    frac_aln = frac_sml >> shamt;
    if (sign_big == sign_sml) sum = {1'b0, frac_big} + {1'b0, frac_aln};
    else                      sum = {1'b0, frac_big} - {1'b0, frac_aln};
    carry = sum[FW];
    lz = 3'd7;
    for (int i = 1; i <= 7; i++) begin
      if (sum[i]) lz = 3'(7 - i);
    end
    res_exp  = '0;
    res_frac = '0;
    if (carry) begin
      res_exp  = exp_big + EW'(1);
      res_frac = sum[FW:1];
    end else if (EW'(lz) > exp_big) begin
      res_exp  = '0;
      res_frac = '0;
    end else begin
      res_exp  = exp_big - EW'(lz);
      res_frac = sum[FW-1:0] << lz;
    end
    res_ovf = carry && (exp_big == 4'd15);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      id         <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_id     <= 1'b0;
      out_result <= '0;
      out_ovf    <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            op_a  <= win ? a1 : a0;
            op_b  <= win ? b1 : b0;
            id    <= win;
            gnt0  <= !win;
            gnt1  <= win;
            ptr   <= !win;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          out_result <= {sign_big, res_exp, res_frac};
          out_ovf    <= res_ovf;
          out_id     <= id;
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
